// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot-product accumulator controller.
package dot_acc_pkg;

    localparam int unsigned ACC_W         = 32;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned DEF_N_TERMS   = 4;
    localparam int unsigned DEF_N_RESULTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_acc_ctrl_mac_unit.sv
// Registered signed multiply-accumulate; clear has priority over accumulate.
module mac_unit
    import dot_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic [ACC_W-1:0]         acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;

    // Full-width signed product, sign-extended; sum wraps modulo 2^ACC_W.
    assign prod     = a * b;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/dot_acc_ctrl.sv
// Accumulates N_TERMS signed products per result and writes N_RESULTS results
// to consecutive output_mem addresses, then pulses Done.
module dot_acc_ctrl
    import dot_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned N_TERMS   = DEF_N_TERMS,
    parameter int unsigned N_RESULTS = DEF_N_RESULTS
) (
    input  logic              Clock,
    input  logic              Res,
    input  logic              Start,
    input  logic              In_valid,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    output logic              In_ready,
    output logic              En_out_mem,
    output logic [ADDR_W-1:0] Addr_mem_o,
    output logic [ACC_W-1:0]  Data_o,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] TERM_LAST = CNT_W'(N_TERMS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_RESULTS - 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    term_cnt;
    logic [IDX_W-1:0]    res_idx;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    data_hold;
    logic [ADDR_W-1:0]   addr_hold;
    logic                hs;
    logic                mac_clr;
    logic                term_clr;
    logic                idx_clr;
    logic                idx_inc;

    assign hs = In_valid & (state == ST_ACC);

    mac_unit #(.DATA_W(DATA_W)) u_mac (
        .clk   (Clock),
        .rst_n (Res),
        .clr   (mac_clr),
        .en    (hs),
        .a     ($signed(A_in)),
        .b     ($signed(B_in)),
        .acc   (acc)
    );

    always_ff @(posedge Clock or negedge Res) begin
        if (!Res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and counter/accumulator control.
    always_comb begin
        state_next = state;
        mac_clr    = 1'b0;
        term_clr   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_ACC;
                    mac_clr    = 1'b1;
                    term_clr   = 1'b1;
                    idx_clr    = 1'b1;
                end
            end
            ST_ACC: begin
                if (hs && (term_cnt == TERM_LAST)) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (res_idx == IDX_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_ACC;
                    mac_clr    = 1'b1;
                    term_clr   = 1'b1;
                    idx_inc    = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Res) begin
        if (!Res) begin
            term_cnt <= '0;
            res_idx  <= '0;
        end else begin
            if (term_clr) begin
                term_cnt <= '0;
            end else if (hs) begin
                term_cnt <= term_cnt + CNT_W'(1);
            end
            if (idx_clr) begin
                res_idx <= '0;
            end else if (idx_inc) begin
                res_idx <= res_idx + IDX_W'(1);
            end
        end
    end

    // Write port keeps showing the last written word once WRITE is over.
    always_ff @(posedge Clock or negedge Res) begin
        if (!Res) begin
            data_hold <= '0;
            addr_hold <= '0;
        end else if (state == ST_WRITE) begin
            data_hold <= acc;
            addr_hold <= ADDR_W'(res_idx);
        end
    end

    assign In_ready   = (state == ST_ACC);
    assign En_out_mem = (state == ST_WRITE);
    assign Busy       = (state != ST_IDLE);
    assign Done       = (state == ST_DONE);
    assign Data_o     = (state == ST_WRITE) ? acc : data_hold;
    assign Addr_mem_o = (state == ST_WRITE) ? ADDR_W'(res_idx) : addr_hold;

endmodule

// File: tb/tb_dot_acc_ctrl.sv
// Self-checking bench for dot_acc_ctrl: vector table, corner sequences and
// randomized jobs against a transaction-level reference model.
module tb_dot_acc_ctrl;

    localparam int NT = 4;
    localparam int NR = 4;

    localparam int PH_IDLE  = 10;
    localparam int PH_SUM   = 11;
    localparam int PH_WRITE = 12;
    localparam int PH_DONE  = 13;

    logic        clk = 1'b0;
    logic        res_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_ready;
    logic        en_out_mem;
    logic [2:0]  addr_mem;
    logic [31:0] data_o;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    dot_acc_ctrl #(.DATA_W(8), .N_TERMS(NT), .N_RESULTS(NR)) dut (
        .Clock      (clk),
        .Res        (res_n),
        .Start      (start),
        .In_valid   (in_valid),
        .A_in       (a_in),
        .B_in       (b_in),
        .In_ready   (in_ready),
        .En_out_mem (en_out_mem),
        .Addr_mem_o (addr_mem),
        .Data_o     (data_o),
        .Busy       (busy),
        .Done       (done)
    );

    typedef struct {
        logic [7:0]  a [NT];
        logic [7:0]  b [NT];
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [8];
    logic [7:0]  ja [NR][NT];
    logic [7:0]  jb [NR][NT];
    logic [31:0] jexp [NR];
    logic [31:0] mem_seen [NR];
    int          n_writes;
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference model: job phase, running sum and last written word.
    int          m_phase;
    int          m_terms;
    int          m_ridx;
    longint      m_sum;
    logic [31:0] m_data;
    logic [2:0]  m_addr;
    bit          m_hs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endfunction

    function automatic void model_reset();
        m_phase = PH_IDLE;
        m_terms = 0;
        m_ridx  = 0;
        m_sum   = 0;
        m_data  = '0;
        m_addr  = '0;
        m_hs    = 1'b0;
    endfunction

    function automatic void model_step();
        m_hs = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (start) begin
                m_phase = PH_SUM;
                m_terms = 0;
                m_ridx  = 0;
                m_sum   = 0;
            end
        end else if (m_phase == PH_SUM) begin
            if (in_valid) begin
                m_hs    = 1'b1;
                m_sum   = m_sum + longint'($signed(a_in)) * longint'($signed(b_in));
                m_terms = m_terms + 1;
                if (m_terms == NT) begin
                    m_phase = PH_WRITE;
                    m_addr  = 3'(m_ridx);
                    m_data  = 32'(m_sum);
                end
            end
        end else if (m_phase == PH_WRITE) begin
            if (m_ridx == NR - 1) begin
                m_phase = PH_DONE;
            end else begin
                m_phase = PH_SUM;
                m_ridx  = m_ridx + 1;
                m_sum   = 0;
                m_terms = 0;
            end
        end else begin
            m_phase = PH_IDLE;
        end
    endfunction

    function automatic void check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_phase == PH_SUM));
        chk("en_out_mem", 32'(en_out_mem), 32'(m_phase == PH_WRITE));
        chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        chk("done", 32'(done), 32'(m_phase == PH_DONE));
        chk("addr_mem_o", 32'(addr_mem), 32'(m_addr));
        chk("data_o", data_o, m_data);
        if (en_out_mem === 1'b1) begin
            mem_seen[addr_mem[1:0]] = data_o;
            n_writes++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Present one pair and hold it until the model says it was consumed.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit gap);
        int k = 0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        do begin
            tick();
            k++;
        end while (!m_hs && k < 20);
        if (!m_hs) timeout("handshake_wait");
        if (gap) begin
            in_valid = 1'b0;
            a_in     = 8'hA5;
            b_in     = 8'h5A;
            tick();
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_phase != PH_IDLE && k < 30) begin
            tick();
            k++;
        end
        if (m_phase != PH_IDLE) timeout("idle_wait");
    endtask

    task automatic run_job(input bit gaps, input bit rand_gaps, input bit hold_start);
        bit g;
        for (int r = 0; r < NR; r++) mem_seen[r] = 'x;
        n_writes = 0;
        start = 1'b1;
        tick();
        start = hold_start;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NT; k++) begin
                if (r == 1 && k == 1) start = 1'b0;
                g = rand_gaps ? bit'($urandom_range(1, 0)) : gaps;
                send_pair(ja[r][k], jb[r][k], g);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        wait_idle();
        chk("write_count", 32'(n_writes), 32'(NR));
        for (int r = 0; r < NR; r++) chk("mem_word", mem_seen[r], jexp[r]);
    endtask

    task automatic load_rows(input int first);
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NT; k++) begin
                ja[r][k] = tbl[first + r].a[k];
                jb[r][k] = tbl[first + r].b[k];
            end
            jexp[r] = tbl[first + r].exp;
        end
    endtask

    task automatic compute_exp();
        int s;
        for (int r = 0; r < NR; r++) begin
            s = 0;
            for (int k = 0; k < NT; k++) s += int'($signed(ja[r][k])) * int'($signed(jb[r][k]));
            jexp[r] = 32'(s);
        end
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        #2;
        res_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{a: '{8'd1, 8'd2, 8'd3, 8'd4},         b: '{8'd5, 8'd6, 8'd7, 8'd8},         exp: 32'h0000_0046};
        tbl[1] = '{a: '{8'h80, 8'h80, 8'h80, 8'h80},     b: '{8'h7F, 8'h7F, 8'h7F, 8'h7F},     exp: 32'hFFFF_0200};
        tbl[2] = '{a: '{8'h80, 8'h80, 8'h80, 8'h80},     b: '{8'h80, 8'h80, 8'h80, 8'h80},     exp: 32'h0001_0000};
        tbl[3] = '{a: '{8'h7F, 8'h7F, 8'h7F, 8'h7F},     b: '{8'h7F, 8'h7F, 8'h7F, 8'h7F},     exp: 32'h0000_FC04};
        tbl[4] = '{a: '{8'hFF, 8'h02, 8'hFD, 8'h04},     b: '{8'h05, 8'hFA, 8'h07, 8'hF8},     exp: 32'hFFFF_FFBA};
        tbl[5] = '{a: '{8'h00, 8'h05, 8'h00, 8'h7F},     b: '{8'h09, 8'h00, 8'h00, 8'h00},     exp: 32'h0000_0000};
        tbl[6] = '{a: '{8'h01, 8'h01, 8'h01, 8'h01},     b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF},     exp: 32'hFFFF_FFFC};
        tbl[7] = '{a: '{8'h7F, 8'h80, 8'h7F, 8'h80},     b: '{8'h80, 8'h80, 8'h80, 8'h80},     exp: 32'h0000_0100};

        res_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        res_n = 1'b1;
        tick();

        // Vector table: back-to-back, then with a bubble after every pair.
        load_rows(0);
        run_job(1'b0, 1'b0, 1'b0);
        load_rows(4);
        run_job(1'b1, 1'b0, 1'b0);

        // Scaled ramp A=k*(r+1), B=1 with toggling valid: results 10,20,30,40.
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NT; k++) begin
                ja[r][k] = 8'((k + 1) * (r + 1));
                jb[r][k] = 8'd1;
            end
            jexp[r] = 32'(10 * (r + 1));
        end
        run_job(1'b1, 1'b0, 1'b0);

        // Abort after two handshakes: no write may follow, next job starts clean.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_pair(8'd3, 8'd4, 1'b0);
        send_pair(8'd5, 8'd6, 1'b0);
        async_reset();
        repeat (6) tick();
        load_rows(0);
        run_job(1'b0, 1'b0, 1'b0);

        // Start held through ACC and the first WRITE, then a restart right after Done.
        load_rows(4);
        run_job(1'b0, 1'b0, 1'b1);
        load_rows(0);
        run_job(1'b0, 1'b0, 1'b0);

        // Randomized operands and valid gaps.
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < NR; r++) begin
                for (int k = 0; k < NT; k++) begin
                    ja[r][k] = 8'($urandom);
                    jb[r][k] = 8'($urandom);
                end
            end
            compute_exp();
            run_job(1'b0, 1'b1, 1'b0);
            repeat (int'($urandom_range(3, 0))) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
